// File: rtl/fare_pkg.sv
// Shared types and defaults for the fare ledger: session states, account record
// layout and the fare-sufficiency helper.
package fare_pkg;

    localparam int BAL_W        = 12;
    localparam int FARE_DEFAULT = 300;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SESSION = 2'd1,
        PAID    = 2'd2
    } state_t;

    typedef struct packed {
        logic             active;
        logic             monthly;
        logic [BAL_W-1:0] bal;
    } acct_t;

    function automatic logic fund_ok(input logic [BAL_W-1:0] bal,
                                     input logic [BAL_W-1:0] fare);
        return bal >= fare;
    endfunction

endpackage

// File: rtl/fare_ledger_if.sv
// Check/deduct/top-up bundle between the gate side (master) and the ledger
// (slave).
interface fare_ledger_if
    import fare_pkg::*;
#(
    parameter int ID_W = 3
);
    logic             nfc;
    logic [ID_W-1:0]  card_id;
    logic             reduce_bal;
    logic             load_en;
    logic [ID_W-1:0]  load_id;
    logic [BAL_W-1:0] load_bal;
    logic             load_active;
    logic             load_monthly;

    logic             resp_valid;
    logic             card_active;
    logic             fund_enough;
    logic             monthly;
    logic [BAL_W-1:0] balance;
    logic             deduct_done;
    logic             deduct_err;

    modport master (
        output nfc, card_id, reduce_bal, load_en, load_id, load_bal, load_active, load_monthly,
        input  resp_valid, card_active, fund_enough, monthly, balance, deduct_done, deduct_err
    );

    modport slave (
        input  nfc, card_id, reduce_bal, load_en, load_id, load_bal, load_active, load_monthly,
        output resp_valid, card_active, fund_enough, monthly, balance, deduct_done, deduct_err
    );
endinterface

// File: rtl/fare_table.sv
// Account register array: one combinational read port, a full-entry write port
// and a balance-only deduct port; the full write wins when both hit one entry.
module fare_table
    import fare_pkg::*;
#(
    parameter int NUM_CARDS = 8,
    parameter int ID_W      = $clog2(NUM_CARDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ID_W-1:0]  rd_id,
    output acct_t            rd_data,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_id,
    input  acct_t            wr_data,
    input  logic             ded_en,
    input  logic [ID_W-1:0]  ded_id,
    input  logic [BAL_W-1:0] ded_bal
);

    acct_t mem [NUM_CARDS];

    assign rd_data = mem[rd_id];

    // NOTE: the table is flops, not RAM, so it can be cleared by reset; a
    // reset is required here because "no account" must read as all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ded_en) begin
                mem[ded_id].bal <= ded_bal;
            end
            if (wr_en) begin
                mem[wr_id] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/fare_ledger.sv
// Card-account responder for the fare gate: tap lookup, single fare deduction
// per session, idle timeout and top-up loads. All outputs are registered.
module fare_ledger
    import fare_pkg::*;
#(
    parameter int NUM_CARDS = 8,
    parameter int FARE      = FARE_DEFAULT,
    parameter int TIMEOUT   = 15
) (
    input logic          clk,
    input logic          reset,
    fare_ledger_if.slave bus
);

    localparam int               ID_W   = $clog2(NUM_CARDS);
    localparam int               CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [BAL_W-1:0] FARE_V = BAL_W'(FARE);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   sess_id_q;
    logic [ID_W-1:0]   rd_id;
    acct_t             rd_ent, look_ent, load_ent;
    logic              same_load, pay_ok, apply, err_d;

    assign load_ent = '{active: bus.load_active, monthly: bus.load_monthly, bal: bus.load_bal};

    // A tap reads the new card; otherwise the port serves the open session.
    assign rd_id = bus.nfc ? bus.card_id : sess_id_q;

    // A tap coinciding with a load of the same card sees the loaded values.
    assign look_ent = (bus.load_en && bus.load_id == bus.card_id) ? load_ent : rd_ent;

    assign same_load = bus.load_en && (bus.load_id == sess_id_q);
    assign pay_ok    = rd_ent.active && !rd_ent.monthly && fund_ok(rd_ent.bal, FARE_V);
    assign apply     = (state_q == SESSION) && bus.reduce_bal && !bus.nfc && pay_ok && !same_load;

    fare_table #(
        .NUM_CARDS (NUM_CARDS),
        .ID_W      (ID_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .rd_id   (rd_id),
        .rd_data (rd_ent),
        .wr_en   (bus.load_en),
        .wr_id   (bus.load_id),
        .wr_data (load_ent),
        .ded_en  (apply),
        .ded_id  (sess_id_q),
        .ded_bal (rd_ent.bal - FARE_V)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = bus.reduce_bal && !apply;
        unique case (state_q)
            IDLE: begin
                if (bus.nfc) begin
                    state_d = SESSION;
                    cnt_d   = '0;
                end
            end
            SESSION, PAID: begin
                if (bus.nfc) begin
                    state_d = SESSION;
                    cnt_d   = '0;
                end else if (bus.reduce_bal) begin
                    cnt_d = '0;
                    if (apply) state_d = PAID;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            sess_id_q        <= '0;
            bus.resp_valid   <= 1'b0;
            bus.card_active  <= 1'b0;
            bus.fund_enough  <= 1'b0;
            bus.monthly      <= 1'b0;
            bus.balance      <= '0;
            bus.deduct_done  <= 1'b0;
            bus.deduct_err   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bus.deduct_done <= apply;
            bus.deduct_err  <= err_d;
            if (bus.nfc) begin
                sess_id_q       <= bus.card_id;
                bus.resp_valid  <= 1'b1;
                bus.card_active <= look_ent.active;
                bus.monthly     <= look_ent.monthly;
                bus.fund_enough <= fund_ok(look_ent.bal, FARE_V);
                bus.balance     <= look_ent.bal;
            end else if (state_d == IDLE) begin
                bus.resp_valid  <= 1'b0;
                bus.card_active <= 1'b0;
                bus.monthly     <= 1'b0;
                bus.fund_enough <= 1'b0;
                bus.balance     <= '0;
            end else if (same_load) begin
                bus.card_active <= bus.load_active;
                bus.monthly     <= bus.load_monthly;
                bus.fund_enough <= fund_ok(bus.load_bal, FARE_V);
                bus.balance     <= bus.load_bal;
            end else if (apply) begin
                bus.balance <= rd_ent.bal - FARE_V;
            end
        end
    end

endmodule
